mult_rr_scheduler: RTL and testbench

//   Shares one INPUT1_WIDTH x INPUT2_WIDTH array multiplier between NUM_REQ requesters.
//   - Round-robin arbitration, one operation in flight at a time.
//   - Drives the multiplier operands and start pulse, and waits a fixed MULT_LATENCY.
//   - Returns the product, tagged with the requester id, over a valid/ready response channel.
//   - Sits between the requester logic and the array multiplier in top_hdl.

---
 rtl/mult_sched_pkg.sv | 27 ++
 rtl/mult_rr_scheduler_if.sv | 38 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/mult_rr_scheduler.sv | 134 +++++++++++++
 tb/tb_mult_rr_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and default sizing for the round-robin multiplier scheduler.
//   state_t      : scheduler FSM states
//   DEF_*        : default build parameters
//   ID_W, PROD_W : requester-id and product widths of the default build
//   clog2_min1   : $clog2 clamped to at least one bit
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int unsigned DEF_INPUT1_WIDTH = 4;
    localparam int unsigned DEF_INPUT2_WIDTH = 5;
    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_MULT_LATENCY = 2;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned ID_W   = clog2_min1(DEF_NUM_REQ);
    localparam int unsigned PROD_W = DEF_INPUT1_WIDTH + DEF_INPUT2_WIDTH;

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// Request, multiplier and response signals of the scheduler.
//   req_valid/req_ready/req_a/req_b : per-requester request channel (packed slices)
//   mult_a/mult_b/mult_start        : operands and start pulse to the multiplier
//   mult_product                    : multiplier result
//   resp_valid/resp_ready/resp_id/resp_product : response channel
// Modports: slave = scheduler view, master = requester/multiplier/consumer view.
interface mult_rr_scheduler_if #(
    parameter int unsigned IN1_W   = mult_sched_pkg::DEF_INPUT1_WIDTH,
    parameter int unsigned IN2_W   = mult_sched_pkg::DEF_INPUT2_WIDTH,
    parameter int unsigned NUM_REQ = mult_sched_pkg::DEF_NUM_REQ
);
    localparam int unsigned W_ID   = mult_sched_pkg::clog2_min1(NUM_REQ);
    localparam int unsigned W_PROD = IN1_W + IN2_W;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*IN1_W-1:0] req_a;
    logic [NUM_REQ*IN2_W-1:0] req_b;
    logic [IN1_W-1:0]         mult_a;
    logic [IN2_W-1:0]         mult_b;
    logic                     mult_start;
    logic [W_PROD-1:0]        mult_product;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [W_ID-1:0]          resp_id;
    logic [W_PROD-1:0]        resp_product;

    modport slave (
        input  req_valid, req_a, req_b, mult_product, resp_ready,
        output req_ready, mult_a, mult_b, mult_start, resp_valid, resp_id, resp_product
    );

    modport master (
        output req_valid, req_a, req_b, mult_product, resp_ready,
        input  req_ready, mult_a, mult_b, mult_start, resp_valid, resp_id, resp_product
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req     : request vector
//   i_ptr     : index of the last grant; search starts at i_ptr+1
//   o_grant_c : one-hot grant
//   o_idx_c   : index of the granted requester
//   o_any_c   : at least one request present
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned W_ID    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [W_ID-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant_c,
    output logic [W_ID-1:0]    o_idx_c,
    output logic               o_any_c
);

    logic [W_ID-1:0] w_pos;

    // Walk ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the first set request wins.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_any_c   = 1'b0;
        w_pos     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_pos = W_ID'((32'(i_ptr) + i) % NUM_REQ);
            if (!o_any_c && i_req[w_pos]) begin
                o_any_c          = 1'b1;
                o_grant_c[w_pos] = 1'b1;
                o_idx_c          = w_pos;
            end
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one array multiplier between NUM_REQ requesters, one operation in flight.
//   clk, rst : clock and synchronous active-high reset
//   sched_if : request channel, multiplier operands/start/product, response channel
//   busy     : high whenever the scheduler is not IDLE
// Flow: IDLE (grant) -> ISSUE (start pulse) -> WAIT (MULT_LATENCY-1 .. 0) -> RESP.
module mult_rr_scheduler
    import mult_sched_pkg::*;
#(
    parameter int unsigned INPUT1_WIDTH = DEF_INPUT1_WIDTH,
    parameter int unsigned INPUT2_WIDTH = DEF_INPUT2_WIDTH,
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned MULT_LATENCY = DEF_MULT_LATENCY
) (
    input  logic               clk,
    input  logic               rst,
    mult_rr_scheduler_if.slave sched_if,
    output logic               busy
);

    localparam int unsigned W_ID   = clog2_min1(NUM_REQ);
    localparam int unsigned W_PROD = INPUT1_WIDTH + INPUT2_WIDTH;
    localparam int unsigned W_CNT  = clog2_min1(MULT_LATENCY + 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [W_ID-1:0]     r_ptr;
    logic [W_CNT-1:0]    r_cnt;
    logic [INPUT1_WIDTH-1:0] r_mult_a;
    logic [INPUT2_WIDTH-1:0] r_mult_b;
    logic [W_ID-1:0]     r_resp_id;
    logic [W_PROD-1:0]   r_resp_product;

    logic [NUM_REQ-1:0]      w_grant;
    logic [W_ID-1:0]         w_grant_idx;
    logic                    w_any;
    logic [INPUT1_WIDTH-1:0] w_sel_a;
    logic [INPUT2_WIDTH-1:0] w_sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req     (sched_if.req_valid),
        .i_ptr     (r_ptr),
        .o_grant_c (w_grant),
        .o_idx_c   (w_grant_idx),
        .o_any_c   (w_any)
    );

    // Operand slices of the requester the arbiter is currently pointing at.
    assign w_sel_a = sched_if.req_a[int'(w_grant_idx)*INPUT1_WIDTH +: INPUT1_WIDTH];
    assign w_sel_b = sched_if.req_b[int'(w_grant_idx)*INPUT2_WIDTH +: INPUT2_WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = ISSUE;
            ISSUE:   w_state_next = (MULT_LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == '0) w_state_next = RESP;
            RESP:    if (sched_if.resp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode; req_ready is the only combinational grant toward requesters.
    always_comb begin
        sched_if.req_ready  = '0;
        sched_if.mult_start = 1'b0;
        sched_if.resp_valid = 1'b0;
        busy                = 1'b1;
        case (r_state)
            IDLE: begin
                sched_if.req_ready = w_grant;
                busy               = 1'b0;
            end
            ISSUE:   sched_if.mult_start = 1'b1;
            RESP:    sched_if.resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand/id capture on accept, latency countdown, product capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr          <= W_ID'(NUM_REQ - 1);
            r_cnt          <= '0;
            r_mult_a       <= '0;
            r_mult_b       <= '0;
            r_resp_id      <= '0;
            r_resp_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_mult_a  <= w_sel_a;
                        r_mult_b  <= w_sel_b;
                        r_resp_id <= w_grant_idx;
                        r_ptr     <= w_grant_idx;
                    end
                end
                ISSUE: begin
                    if (MULT_LATENCY == 0) begin
                        r_resp_product <= sched_if.mult_product;
                    end else begin
                        r_cnt <= W_CNT'(MULT_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_resp_product <= sched_if.mult_product;
                    end else begin
                        r_cnt <= r_cnt - W_CNT'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sched_if.mult_a       = r_mult_a;
    assign sched_if.mult_b       = r_mult_b;
    assign sched_if.resp_id      = r_resp_id;
    assign sched_if.resp_product = r_resp_product;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: a latency-2 and a latency-0 build share one stimulus stream.
module tb_mult_rr_scheduler;
    import mult_sched_pkg::*;

    localparam int unsigned A_W = DEF_INPUT1_WIDTH;
    localparam int unsigned B_W = DEF_INPUT2_WIDTH;
    localparam int unsigned N   = DEF_NUM_REQ;
    localparam int unsigned I_W = ID_W;
    localparam int unsigned P_W = PROD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]     req_valid = '0;
    logic [N*A_W-1:0] req_a     = '0;
    logic [N*B_W-1:0] req_b     = '0;
    logic             resp_ready = 1'b1;
    logic             busy0, busy1;

    mult_rr_scheduler_if #(.IN1_W(A_W), .IN2_W(B_W), .NUM_REQ(N)) if0 ();
    mult_rr_scheduler_if #(.IN1_W(A_W), .IN2_W(B_W), .NUM_REQ(N)) if1 ();

    assign if0.req_valid  = req_valid;
    assign if0.req_a      = req_a;
    assign if0.req_b      = req_b;
    assign if0.resp_ready = resp_ready;
    assign if1.req_valid  = req_valid;
    assign if1.req_a      = req_a;
    assign if1.req_b      = req_b;
    assign if1.resp_ready = resp_ready;

    mult_rr_scheduler #(.INPUT1_WIDTH(A_W), .INPUT2_WIDTH(B_W), .NUM_REQ(N), .MULT_LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .sched_if(if0.slave), .busy(busy0));
    mult_rr_scheduler #(.INPUT1_WIDTH(A_W), .INPUT2_WIDTH(B_W), .NUM_REQ(N), .MULT_LATENCY(0)) dut1 (
        .clk(clk), .rst(rst), .sched_if(if1.slave), .busy(busy1));

    // Multiplier models: the true product appears exactly LATENCY cycles after start, junk otherwise.
    logic [P_W-1:0] m0_s0, m0_s1, m1_junk;
    always_ff @(posedge clk) begin
        m0_s0   <= if0.mult_start ? P_W'(if0.mult_a) * P_W'(if0.mult_b) : P_W'($urandom);
        m0_s1   <= m0_s0;
        m1_junk <= P_W'($urandom);
    end
    assign if0.mult_product = m0_s1;
    assign if1.mult_product = if1.mult_start ? P_W'(if1.mult_a) * P_W'(if1.mult_b) : m1_junk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    // Round-robin rule: first valid requester after 'last', wrapping; -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= int'(N); i++) begin
            logic [N-1:0] sh;
            sh = v >> ((last + i) % int'(N));
            if (sh[0]) return (last + i) % int'(N);
        end
        return -1;
    endfunction

    function automatic int onehot2idx(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++)
            if (((v >> i) & N'(1)) != '0) return i;
        return -1;
    endfunction

    // Transaction-level model: an op accepted in cycle acc starts at acc+1,
    // has its product at acc+1+L, and is offered from acc+2+L until taken.
    bit             m_busy [2];
    int             m_acc  [2];
    int             m_last [2];
    logic [I_W-1:0] m_id   [2];
    logic [A_W-1:0] m_a    [2];
    logic [B_W-1:0] m_b    [2];
    logic [P_W-1:0] m_prod [2];
    int             cyc      = 0;
    bit             seen_rst = 1'b0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int             g;
            logic [N-1:0]   e_rdy;
            bit             e_st, e_rv;
            logic [N-1:0]   a_rdy;
            logic           a_st, a_rv, a_bz;
            logic [A_W-1:0] a_ma;
            logic [B_W-1:0] a_mb;
            logic [I_W-1:0] a_id;
            logic [P_W-1:0] a_pr;
            g     = pick(req_valid, m_last[k]);
            e_rdy = (!m_busy[k] && g >= 0) ? (N'(1) << g) : '0;
            e_st  = m_busy[k] && (cyc == m_acc[k] + 1);
            e_rv  = m_busy[k] && (cyc >= m_acc[k] + 2 + lat(k));
            a_rdy = (k == 0) ? if0.req_ready    : if1.req_ready;
            a_st  = (k == 0) ? if0.mult_start   : if1.mult_start;
            a_rv  = (k == 0) ? if0.resp_valid   : if1.resp_valid;
            a_bz  = (k == 0) ? busy0            : busy1;
            a_ma  = (k == 0) ? if0.mult_a       : if1.mult_a;
            a_mb  = (k == 0) ? if0.mult_b       : if1.mult_b;
            a_id  = (k == 0) ? if0.resp_id      : if1.resp_id;
            a_pr  = (k == 0) ? if0.resp_product : if1.resp_product;
            if (seen_rst) begin
                chk($sformatf("m%0d_req_ready", k),    32'(a_rdy), 32'(e_rdy));
                chk($sformatf("m%0d_mult_start", k),   32'(a_st),  32'(e_st));
                chk($sformatf("m%0d_resp_valid", k),   32'(a_rv),  32'(e_rv));
                chk($sformatf("m%0d_busy", k),         32'(a_bz),  32'(m_busy[k]));
                chk($sformatf("m%0d_mult_a", k),       32'(a_ma),  32'(m_a[k]));
                chk($sformatf("m%0d_mult_b", k),       32'(a_mb),  32'(m_b[k]));
                chk($sformatf("m%0d_resp_id", k),      32'(a_id),  32'(m_id[k]));
                chk($sformatf("m%0d_resp_product", k), 32'(a_pr),  32'(m_prod[k]));
            end
            if (rst) begin
                m_busy[k] = 1'b0; m_last[k] = int'(N) - 1; m_acc[k] = 0;
                m_id[k] = '0; m_a[k] = '0; m_b[k] = '0; m_prod[k] = '0;
            end else if (!m_busy[k]) begin
                if (g >= 0) begin
                    m_busy[k] = 1'b1;
                    m_acc[k]  = cyc;
                    m_last[k] = g;
                    m_id[k]   = I_W'(g);
                    m_a[k]    = A_W'(req_a >> (g * int'(A_W)));
                    m_b[k]    = B_W'(req_b >> (g * int'(B_W)));
                end
            end else if (cyc == m_acc[k] + 1 + lat(k)) begin
                m_prod[k] = P_W'(m_a[k]) * P_W'(m_b[k]);
            end else if (e_rv && resp_ready) begin
                m_busy[k] = 1'b0;
            end
        end
        if (rst) seen_rst = 1'b1;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; resp_ready = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic set_op(input int idx, input int a, input int b);
        req_a[idx*A_W +: A_W] = A_W'(a);
        req_b[idx*B_W +: B_W] = B_W'(b);
    endtask

    // Returns at the negedge of the cycle where instance 0 shows a grant.
    task automatic wait_grant(input string name, output int idx, output int waited);
        idx = -1; waited = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if0.req_ready != '0) begin
                idx = onehot2idx(if0.req_ready);
                waited = i;
                return;
            end
            step();
        end
        fail_timeout(name);
    endtask

    initial begin
        int idx, waited, first, first1;
        logic [I_W-1:0] id_s;
        logic [P_W-1:0] pr_s;
        bit any_rv;

        // Reset values.
        step(); step();
        @(negedge clk);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_resp_valid", 32'(if0.resp_valid), 0);
        chk("rst_mult_start", 32'(if0.mult_start), 0);
        chk("rst_resp_product", 32'(if0.resp_product), 0);
        chk("rst_mult_a", 32'(if0.mult_a), 0);

        // Single op: 15 * 31 from requester 0.
        step();
        rst = 1'b0; set_op(0, 15, 31); req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_req_ready", 32'(if0.req_ready), 32'h1);
        step();
        req_valid = '0;
        first = -1; first1 = -1; id_s = '0; pr_s = '0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (t == 1) begin
                chk("t1_mult_start", 32'(if0.mult_start), 1);
                chk("t1_ready_low", 32'(if0.req_ready), 0);
            end
            if (if0.resp_valid && first < 0) begin
                first = t; id_s = if0.resp_id; pr_s = if0.resp_product;
            end
            if (if1.resp_valid && first1 < 0) first1 = t;
            step();
        end
        chk("t1_latency", 32'(first), 4);
        chk("t1_resp_id", 32'(id_s), 0);
        chk("t1_product", 32'(pr_s), 465);
        chk("t1_latency_l0", 32'(first1), 2);

        // Round robin with all requesting: 0,1,2,3,0 every 5 cycles.
        do_reset();
        req_valid = 4'b1111;
        req_a = (N*A_W)'($urandom); req_b = (N*B_W)'($urandom);
        for (int n = 0; n < 5; n++) begin
            wait_grant($sformatf("t2_grant%0d", n), idx, waited);
            chk($sformatf("t2_grant%0d", n), 32'(idx), 32'(n % 4));
            if (n > 0) chk($sformatf("t2_spacing%0d", n), 32'(waited + 1), 5);
            step();
            req_a = (N*A_W)'($urandom); req_b = (N*B_W)'($urandom);
        end

        // Fairness skip.
        do_reset();
        req_valid = 4'b0010;
        wait_grant("t3_g1", idx, waited);
        chk("t3_first", 32'(idx), 1);
        step();
        req_valid = 4'b0011;
        wait_grant("t3_g2", idx, waited);
        chk("t3_skip_to_0", 32'(idx), 0);
        step();
        wait_grant("t3_g3", idx, waited);
        chk("t3_back_to_1", 32'(idx), 1);
        step();

        // Backpressure: 9 * 13 held for 10 stalled cycles.
        do_reset();
        resp_ready = 1'b0; set_op(0, 9, 13); req_valid = 4'b0001;
        wait_grant("t4_grant", idx, waited);
        step();
        req_valid = 4'b1111;
        first = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (if0.resp_valid) begin first = t; break; end
            step();
        end
        if (first < 0) fail_timeout("t4_resp_valid");
        chk("t4_id", 32'(if0.resp_id), 0);
        chk("t4_product", 32'(if0.resp_product), 117);
        for (int t = 0; t < 10; t++) begin
            step();
            @(negedge clk);
            chk("t4_hold_valid", 32'(if0.resp_valid), 1);
            chk("t4_hold_id", 32'(if0.resp_id), 0);
            chk("t4_hold_product", 32'(if0.resp_product), 117);
            chk("t4_hold_ready", 32'(if0.req_ready), 0);
        end
        step();
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_valid", 32'(if0.resp_valid), 1);
        chk("t4_release_no_accept", 32'(if0.req_ready), 0);
        step();
        @(negedge clk);
        chk("t4_idle_busy", 32'(busy0), 0);
        chk("t4_idle_valid", 32'(if0.resp_valid), 0);
        chk("t4_idle_grant", 32'(if0.req_ready), 32'h2);
        step();
        req_valid = '0;

        // Reset in WAIT drops the operation.
        do_reset();
        set_op(0, $urandom_range(1, 15), $urandom_range(1, 31)); req_valid = 4'b0001;
        wait_grant("t5_grant", idx, waited);
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_in_wait", 32'(busy0), 1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy0), 0);
        chk("t5_valid", 32'(if0.resp_valid), 0);
        any_rv = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            @(negedge clk);
            if (if0.resp_valid) any_rv = 1'b1;
        end
        chk("t5_no_resp", 32'(any_rv), 0);
        step();
        req_valid = 4'b1111;
        wait_grant("t5_regrant", idx, waited);
        chk("t5_grant0", 32'(idx), 0);
        step();

        // Latency-0 build: 3 * 7.
        do_reset();
        set_op(0, 3, 7); req_valid = 4'b0001;
        @(negedge clk);
        chk("t6_req_ready", 32'(if1.req_ready), 32'h1);
        step();
        req_valid = '0;
        first = -1; pr_s = '0;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (if1.resp_valid && first < 0) begin first = t; pr_s = if1.resp_product; end
            step();
        end
        chk("t6_latency", 32'(first), 2);
        chk("t6_product", 32'(pr_s), 21);

        // Random traffic, checked every cycle by the model.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            req_valid  = N'($urandom);
            req_a      = (N*A_W)'($urandom);
            req_b      = (N*B_W)'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
